// File: rtl/tl45_pkg.sv
// Shared TL45 definitions: memory-stage opcodes, access sizes and FSM state codes.
package tl45_pkg;

    localparam logic [4:0] OP_IN  = 5'd10;
    localparam logic [4:0] OP_OUT = 5'd11;
    localparam logic [4:0] OP_LW  = 5'd14;
    localparam logic [4:0] OP_SW  = 5'd15;

    typedef enum logic [1:0] {
        SZ_BYTE     = 2'b00,
        SZ_HALF     = 2'b01,
        SZ_WORD     = 2'b10,
        SZ_WORD_ALT = 2'b11
    } mem_size_t;

    typedef logic [2:0] mem_state_t;

    localparam mem_state_t ST_IDLE   = 3'd0;
    localparam mem_state_t ST_STROBE = 3'd1;
    localparam mem_state_t ST_WAIT   = 3'd2;
    localparam mem_state_t ST_HOLD   = 3'd3;
    localparam mem_state_t ST_DONE   = 3'd4;

    // Byte accesses are always aligned; both word encodings need a 4-byte boundary.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        case (mem_size_t'(size))
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = addr_lo[0];
            default: mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/tl45_mem_lane.sv
// Byte-lane steering: select generation and write replication on the way out,
// lane extraction and sign/zero extension on the way back.
module tl45_mem_lane
    import tl45_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        sext,
    input  logic [31:0] wdata_in,
    input  logic [31:0] rdata_in,
    output logic [3:0]  sel,
    output logic [31:0] wdata_out,
    output logic [31:0] rdata_out
);

    logic [31:0] shifted;

    always_comb begin
        shifted   = rdata_in >> {addr_lo, 3'b000};
        sel       = 4'b1111;
        wdata_out = wdata_in;
        rdata_out = shifted;
        case (mem_size_t'(size))
            SZ_BYTE: begin
                sel       = 4'b0001 << addr_lo;
                wdata_out = {4{wdata_in[7:0]}};
                rdata_out = {{24{sext & shifted[7]}}, shifted[7:0]};
            end
            SZ_HALF: begin
                sel       = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_out = {2{wdata_in[15:0]}};
                rdata_out = {{16{sext & shifted[15]}}, shifted[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/tl45_mem_stage.sv
// TL45 memory stage: byte/half/word loads and stores as a single-outstanding
// Wishbone B4 pipelined master, with misalignment, bus-error and watchdog faults.
module tl45_mem_stage
    import tl45_pkg::*;
#(
    parameter int unsigned AW      = 30,
    parameter logic [15:0] IO_BASE = 16'h00ff,
    parameter logic [31:0] ERR_VAL = 32'h13371337,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_pipe_stall,
    output logic          o_pipe_stall,
    input  logic          i_pipe_flush,
    output logic          o_pipe_flush,
    output logic          o_wb_cyc,
    output logic          o_wb_stb,
    output logic          o_wb_we,
    output logic [AW-1:0] o_wb_addr,
    output logic [31:0]   o_wb_data,
    output logic [3:0]    o_wb_sel,
    input  logic          i_wb_ack,
    input  logic          i_wb_stall,
    input  logic          i_wb_err,
    input  logic [31:0]   i_wb_data,
    input  logic [4:0]    i_buf_opcode,
    input  logic [1:0]    i_buf_size,
    input  logic          i_buf_sext,
    input  logic [3:0]    i_buf_dr,
    input  logic [31:0]   i_buf_sr1_val,
    input  logic [31:0]   i_buf_sr2_val,
    input  logic [31:0]   i_buf_imm,
    output logic [3:0]    o_fwd_dr,
    output logic [31:0]   o_fwd_val,
    output logic [3:0]    o_buf_dr,
    output logic [31:0]   o_buf_val,
    output logic          o_fault,
    output logic [2:0]    o_dbg_state
);

    localparam logic        WD_EN   = (TIMEOUT != 0);
    localparam logic [15:0] WD_LAST = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

    mem_state_t  state;
    logic [1:0]  lat_size, lat_alo;
    logic        lat_sext, lat_write;
    logic [3:0]  lat_dr;
    logic [31:0] result;
    logic [15:0] wdog;

    logic        is_io, is_start, is_write_op, misaligned, can_accept, busy;
    logic        wd_expire, bus_resp, completing, bus_fault;
    logic [1:0]  req_size, lane_size, lane_alo;
    logic [31:0] req_addr, req_wdata, bus_data, lane_wdata, lane_rdata;
    logic [3:0]  lane_sel;

    // Handshake: an op is taken when the opcode is a memory op, the stage is in
    // IDLE or DONE and i_pipe_stall is low; while the bus access is outstanding
    // o_pipe_stall holds the op upstream, so nothing else gates acceptance.
    always_comb begin
        is_io       = (i_buf_opcode == OP_IN) || (i_buf_opcode == OP_OUT);
        is_start    = is_io || (i_buf_opcode == OP_LW) || (i_buf_opcode == OP_SW);
        is_write_op = (i_buf_opcode == OP_OUT) || (i_buf_opcode == OP_SW);
        req_size    = is_io ? SZ_WORD : i_buf_size;
        req_addr    = is_io ? {IO_BASE, i_buf_imm[13:0], 2'b00} : (i_buf_sr1_val + i_buf_imm);
        req_wdata   = is_io ? i_buf_sr1_val : i_buf_sr2_val;
        misaligned  = is_misaligned(req_size, req_addr[1:0]);
        can_accept  = ((state == ST_IDLE) || (state == ST_DONE)) && is_start && !i_pipe_stall;
        busy        = (state == ST_STROBE) || (state == ST_WAIT);
        wd_expire   = WD_EN && busy && (wdog == WD_LAST);
        // A response in STROBE only counts once the request has actually been taken.
        bus_resp    = (i_wb_ack || i_wb_err) &&
                      ((state == ST_WAIT) || ((state == ST_STROBE) && !i_wb_stall));
        completing  = bus_resp || wd_expire;
        bus_fault   = wd_expire || (bus_resp && i_wb_err);
        bus_data    = bus_fault ? ERR_VAL : lane_rdata;
        lane_size   = busy ? lat_size : req_size;
        lane_alo    = busy ? lat_alo  : req_addr[1:0];
    end

    tl45_mem_lane u_lane (
        .size      (lane_size),
        .addr_lo   (lane_alo),
        .sext      (lat_sext),
        .wdata_in  (req_wdata),
        .rdata_in  (i_wb_data),
        .sel       (lane_sel),
        .wdata_out (lane_wdata),
        .rdata_out (lane_rdata)
    );

    always_comb begin
        o_fwd_dr  = 4'd0;
        o_fwd_val = 32'd0;
        if (state == ST_HOLD) begin
            o_fwd_dr  = lat_dr;
            o_fwd_val = result;
        end else if (completing && !lat_write && !i_pipe_stall) begin
            o_fwd_dr  = lat_dr;
            o_fwd_val = bus_data;
        end
    end

    assign o_pipe_stall = i_pipe_stall || busy;
    assign o_pipe_flush = i_pipe_flush;
    assign o_dbg_state  = state;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_pipe_flush) begin
            state     <= ST_IDLE;
            o_wb_cyc  <= 1'b0;
            o_wb_stb  <= 1'b0;
            o_wb_we   <= 1'b0;
            o_wb_addr <= '0;
            o_wb_data <= 32'd0;
            o_wb_sel  <= 4'd0;
            o_buf_dr  <= 4'd0;
            o_buf_val <= 32'd0;
            o_fault   <= 1'b0;
            wdog      <= 16'd0;
            lat_size  <= 2'd0;
            lat_alo   <= 2'd0;
            lat_sext  <= 1'b0;
            lat_write <= 1'b0;
            lat_dr    <= 4'd0;
            result    <= 32'd0;
        end else begin
            o_fault <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    o_buf_dr  <= 4'd0;
                    o_buf_val <= 32'd0;
                    wdog      <= 16'd0;
                    state     <= ST_IDLE;
                    if (can_accept) begin
                        lat_size  <= req_size;
                        lat_alo   <= req_addr[1:0];
                        lat_sext  <= i_buf_sext;
                        lat_write <= is_write_op;
                        lat_dr    <= i_buf_dr;
                        if (misaligned) begin
                            o_fault <= 1'b1;
                            if (!is_write_op) begin
                                state     <= ST_DONE;
                                o_buf_dr  <= i_buf_dr;
                                o_buf_val <= ERR_VAL;
                            end
                        end else begin
                            state     <= ST_STROBE;
                            o_wb_cyc  <= 1'b1;
                            o_wb_stb  <= 1'b1;
                            o_wb_we   <= is_write_op;
                            o_wb_addr <= req_addr[AW+1:2];
                            o_wb_sel  <= lane_sel;
                            o_wb_data <= lane_wdata;
                        end
                    end
                end
                ST_STROBE, ST_WAIT: begin
                    wdog <= wdog + 16'd1;
                    if ((state == ST_STROBE) && !i_wb_stall) begin
                        o_wb_stb <= 1'b0;
                        state    <= ST_WAIT;
                    end
                    if (completing) begin
                        o_wb_cyc <= 1'b0;
                        o_wb_stb <= 1'b0;
                        o_wb_we  <= 1'b0;
                        wdog     <= 16'd0;
                        o_fault  <= bus_fault;
                        if (lat_write) begin
                            state <= ST_IDLE;
                        end else if (i_pipe_stall) begin
                            state  <= ST_HOLD;
                            result <= bus_data;
                        end else begin
                            state     <= ST_DONE;
                            o_buf_dr  <= lat_dr;
                            o_buf_val <= bus_data;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!i_pipe_stall) begin
                        state     <= ST_DONE;
                        o_buf_dr  <= lat_dr;
                        o_buf_val <= result;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
